// File: rtl/ddr_mem_arbiter.sv
// Two-requester arbiter/sequencer for the 8x8 DDR DRAM macro: IDLE -> ISSUE -> WAIT -> ACK.
// Define DDR_ARB_RR_EN for round-robin tie-break; otherwise A has fixed priority on ties.
module ddr_mem_arbiter #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_a_req,
  input  logic              i_a_rw,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  output logic              o_a_ack,
  output logic [DATA_W-1:0] o_a_rdata,
  input  logic              i_b_req,
  input  logic              i_b_rw,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_wdata,
  output logic              o_b_ack,
  output logic [DATA_W-1:0] o_b_rdata,
  output logic              o_mem_enable,
  output logic              o_mem_rw,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  input  logic [DATA_W-1:0] i_mem_read,
  output logic              o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_grant_b;
  logic              w_load;
  logic              w_enable_nxt;
  logic              w_ack_nxt;
  logic              r_grant_b;
  logic              r_mem_enable;
  logic              r_mem_rw;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data;
  logic              r_a_ack;
  logic              r_b_ack;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;
  logic              r_busy;

`ifdef DDR_ARB_RR_EN
  logic r_last_b;

  // Tie goes to whoever was not granted last.
  always_comb begin
    w_grant_b = i_b_req;
    if (i_a_req && i_b_req) begin
      w_grant_b = ~r_last_b;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_b <= 1'b1;
    end else if (w_load) begin
      r_last_b <= w_grant_b;
    end
  end
`else
  // A wins every tie.
  always_comb begin
    w_grant_b = i_b_req & ~i_a_req;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_enable_nxt = 1'b0;
    w_ack_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_a_req || i_b_req) begin
          w_state_nxt  = S_ISSUE;
          w_load       = 1'b1;
          w_enable_nxt = 1'b1;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        w_state_nxt = S_ACK;
        w_ack_nxt   = 1'b1;
      end
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Command registers double as the memory pin drivers; they hold until the next grant.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_grant_b    <= 1'b0;
      r_mem_enable <= 1'b0;
      r_mem_rw     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_a_ack      <= 1'b0;
      r_b_ack      <= 1'b0;
      r_a_rdata    <= '0;
      r_b_rdata    <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_mem_enable <= w_enable_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_a_ack      <= w_ack_nxt & ~r_grant_b;
      r_b_ack      <= w_ack_nxt & r_grant_b;
      if (w_load) begin
        r_grant_b  <= w_grant_b;
        r_mem_rw   <= w_grant_b ? i_b_rw    : i_a_rw;
        r_mem_addr <= w_grant_b ? i_b_addr  : i_a_addr;
        r_mem_data <= w_grant_b ? i_b_wdata : i_a_wdata;
      end
      if (w_ack_nxt && !r_mem_rw) begin
        if (r_grant_b) begin
          r_b_rdata <= i_mem_read;
        end else begin
          r_a_rdata <= i_mem_read;
        end
      end
    end
  end

  assign o_mem_enable = r_mem_enable;
  assign o_mem_rw     = r_mem_rw;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_data   = r_mem_data;
  assign o_a_ack      = r_a_ack;
  assign o_b_ack      = r_b_ack;
  assign o_a_rdata    = r_a_rdata;
  assign o_b_rdata    = r_b_rdata;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_ddr_mem_arbiter.sv
// Self-checking bench for ddr_mem_arbiter with a behavioural DDR memory and a command-level model.
module tb_ddr_mem_arbiter;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 8;
`ifdef DDR_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              a_req, a_rw, b_req, b_rw;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata;
  logic              a_ack, b_ack;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic              mem_enable, mem_rw, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data, mem_read;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [DATA_W-1:0] m_mem [0:7];
  logic              m_last_b;
  logic [DATA_W-1:0] m_a_rdata, m_b_rdata;

  // Observations taken by the sequencing tasks
  logic              obs_busy0, obs_en0, obs_busy3;
  logic [1:0]        obs_ack1, obs_ack2, obs_ack3;
  logic [DATA_W-1:0] obs_ar, obs_br;

  always #5 clk = ~clk;

  ddr_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_req(a_req), .i_a_rw(a_rw), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .o_a_ack(a_ack), .o_a_rdata(a_rdata),
    .i_b_req(b_req), .i_b_rw(b_rw), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_ack(b_ack), .o_b_rdata(b_rdata),
    .o_mem_enable(mem_enable), .o_mem_rw(mem_rw), .o_mem_addr(mem_addr),
    .o_mem_data(mem_data), .i_mem_read(mem_read), .o_busy(busy)
  );

  // DDR macro stand-in: writes on both edges while enabled, registered read on the rising edge.
  logic [DATA_W-1:0] ram [0:7];
  logic [DATA_W-1:0] ram_rd;
  always @(posedge clk or negedge clk) begin
    if (mem_enable && mem_rw) ram[mem_addr] <= mem_data;
    if (clk && mem_enable && !mem_rw) ram_rd <= ram[mem_addr];
  end
  assign mem_read = ram_rd;

  function automatic logic pick_b(input logic ra, input logic rb);
    if (ra && rb) return RR_EN ? !m_last_b : 1'b0;
    return rb;
  endfunction

  task automatic model_commit(input logic win_b, input logic rw, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] data);
    if (rw) m_mem[addr] = data;
    else if (win_b) m_b_rdata = m_mem[addr];
    else m_a_rdata = m_mem[addr];
    m_last_b = win_b;
  endtask

  task automatic model_reset();
    m_last_b  = 1'b1;
    m_a_rdata = '0;
    m_b_rdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Grant edge through the edge that raises ack; requesters may react after this returns.
  task automatic grant_cycle();
    step();
    obs_busy0 = busy;
    obs_en0   = mem_enable;
    step();
    obs_ack1 = {a_ack, b_ack};
    step();
    obs_ack2 = {a_ack, b_ack};
    obs_ar   = a_rdata;
    obs_br   = b_rdata;
  endtask

  task automatic close_cycle();
    step();
    obs_ack3  = {a_ack, b_ack};
    obs_busy3 = busy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    a_req = 0; a_rw = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_rw = 0; b_addr = '0; b_wdata = '0;
    do_reset();
    n_checks++;
    if ({mem_enable, mem_rw, mem_addr, mem_data, a_ack, b_ack, busy} !== '0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %h expected 0", {mem_enable, mem_rw, mem_addr, mem_data, a_ack, b_ack, busy});
    end
    n_checks++;
    if ({a_rdata, b_rdata} !== '0) begin
      n_errors++;
      $display("FAIL reset_rdata: got %h expected 0", {a_rdata, b_rdata});
    end
    step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_no_req: busy got %b expected 0", busy);
    end
  endtask

  task automatic test_write_read_a();
    a_req = 1; a_rw = 1; a_addr = 3; a_wdata = 8'h5A;
    grant_cycle();
    model_commit(1'b0, 1'b1, 3'd3, 8'h5A);
    n_checks++;
    if ({obs_busy0, obs_en0} !== 2'b11) begin
      n_errors++;
      $display("FAIL wr_issue: busy/en got %b expected 11", {obs_busy0, obs_en0});
    end
    n_checks++;
    if (obs_ack1 !== 2'b00 || obs_ack2 !== 2'b10) begin
      n_errors++;
      $display("FAIL wr_ack_timing: got %b,%b expected 00,10", obs_ack1, obs_ack2);
    end
    a_req = 0;
    close_cycle();
    n_checks++;
    if ({obs_ack3, obs_busy3} !== 3'b000) begin
      n_errors++;
      $display("FAIL wr_ack_pulse: ack/busy got %b expected 000", {obs_ack3, obs_busy3});
    end
    a_req = 1; a_rw = 0;
    grant_cycle();
    model_commit(1'b0, 1'b0, 3'd3, '0);
    n_checks++;
    if (obs_ack2 !== 2'b10 || obs_ar !== m_a_rdata) begin
      n_errors++;
      $display("FAIL rd_a3: ack %b rdata %h expected 10 %h", obs_ack2, obs_ar, m_a_rdata);
    end
    a_req = 0;
    close_cycle();
  endtask

  task automatic test_cross_port();
    b_req = 1; b_rw = 1; b_addr = 7; b_wdata = 8'hC3;
    grant_cycle();
    model_commit(1'b1, 1'b1, 3'd7, 8'hC3);
    n_checks++;
    if (obs_ack2 !== 2'b01) begin
      n_errors++;
      $display("FAIL b_wr7_ack: got %b expected 01", obs_ack2);
    end
    b_req = 0;
    close_cycle();
    a_req = 1; a_rw = 0; a_addr = 7;
    grant_cycle();
    model_commit(1'b0, 1'b0, 3'd7, '0);
    n_checks++;
    if (obs_ar !== m_a_rdata || obs_br !== m_b_rdata) begin
      n_errors++;
      $display("FAIL cross_rd7: a %h b %h expected %h %h", obs_ar, obs_br, m_a_rdata, m_b_rdata);
    end
    a_req = 0;
    close_cycle();
  endtask

  task automatic test_simultaneous();
    logic exp_b;
    do_reset();
    a_req = 1; a_rw = 1; a_addr = 1; a_wdata = 8'h11;
    b_req = 1; b_rw = 1; b_addr = 2; b_wdata = 8'h22;
    for (int g = 0; g < 4; g++) begin
      exp_b = pick_b(1'b1, 1'b1);
      grant_cycle();
      model_commit(exp_b, 1'b1, exp_b ? 3'd2 : 3'd1, exp_b ? 8'h22 : 8'h11);
      n_checks++;
      if (obs_ack2 !== (exp_b ? 2'b01 : 2'b10)) begin
        n_errors++;
        $display("FAIL tie_grant%0d: ack got %b expected %b", g, obs_ack2, exp_b ? 2'b01 : 2'b10);
      end
      close_cycle();
      n_checks++;
      if (obs_ack3 !== 2'b00) begin
        n_errors++;
        $display("FAIL tie_pulse%0d: ack got %b expected 00", g, obs_ack3);
      end
    end
    a_req = 0; b_req = 0;
    step();
  endtask

  task automatic test_reset_mid();
    a_req = 1; a_rw = 0; a_addr = 3;
    step();
    step();
    rst = 1; a_req = 0;
    step();
    rst = 0;
    model_reset();
    n_checks++;
    if ({mem_enable, mem_rw, mem_addr, mem_data, a_ack, b_ack, busy, a_rdata, b_rdata} !== '0) begin
      n_errors++;
      $display("FAIL rst_mid_outputs: got %h expected 0",
               {mem_enable, mem_rw, mem_addr, mem_data, a_ack, b_ack, busy, a_rdata, b_rdata});
    end
    step();
    n_checks++;
    if ({a_ack, b_ack, busy} !== 3'b000) begin
      n_errors++;
      $display("FAIL rst_mid_no_ack: got %b expected 000", {a_ack, b_ack, busy});
    end
    a_req = 1;
    grant_cycle();
    model_commit(1'b0, 1'b0, 3'd3, '0);
    n_checks++;
    if (obs_ack2 !== 2'b10 || obs_ar !== m_a_rdata) begin
      n_errors++;
      $display("FAIL rst_mid_resume: ack %b rdata %h expected 10 %h", obs_ack2, obs_ar, m_a_rdata);
    end
    a_req = 0;
    close_cycle();
  endtask

  task automatic test_held_request();
    logic [DATA_W-1:0] d;
    d = DATA_W'($urandom);
    a_req = 1; a_rw = 1; a_addr = 5; a_wdata = d;
    grant_cycle();
    model_commit(1'b0, 1'b1, 3'd5, d);
    a_rw = 0;
    close_cycle();
    n_checks++;
    if ({obs_ack3, obs_busy3} !== 3'b000) begin
      n_errors++;
      $display("FAIL held_not_n3: ack/busy got %b expected 000", {obs_ack3, obs_busy3});
    end
    grant_cycle();
    model_commit(1'b0, 1'b0, 3'd5, '0);
    n_checks++;
    if (obs_busy0 !== 1'b1 || obs_ack2 !== 2'b10 || obs_ar !== m_a_rdata) begin
      n_errors++;
      $display("FAIL held_n4: busy %b ack %b rdata %h expected 1 10 %h", obs_busy0, obs_ack2, obs_ar, m_a_rdata);
    end
    a_req = 0;
    close_cycle();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      b_req = 1; b_rw = 1; b_addr = ADDR_W'(i); b_wdata = DATA_W'($urandom);
      grant_cycle();
      model_commit(1'b1, 1'b1, b_addr, b_wdata);
      n_checks++;
      if (obs_ack2 !== 2'b01) begin
        n_errors++;
        $display("FAIL fill%0d: ack got %b expected 01", i, obs_ack2);
      end
      b_req = 0;
      close_cycle();
    end
  endtask

  task automatic test_random();
    logic              win_b, rw;
    logic [ADDR_W-1:0] ad;
    logic [DATA_W-1:0] wd;
    for (int it = 0; it < 80; it++) begin
      if (!a_req && $urandom_range(0, 1) == 1) begin
        a_req = 1; a_rw = 1'($urandom_range(0, 1)); a_addr = ADDR_W'($urandom); a_wdata = DATA_W'($urandom);
      end
      if (!b_req && $urandom_range(0, 1) == 1) begin
        b_req = 1; b_rw = 1'($urandom_range(0, 1)); b_addr = ADDR_W'($urandom); b_wdata = DATA_W'($urandom);
      end
      if (!a_req && !b_req) begin
        step();
        n_checks++;
        if ({busy, a_ack, b_ack} !== 3'b000) begin
          n_errors++;
          $display("FAIL rnd_idle%0d: got %b expected 000", it, {busy, a_ack, b_ack});
        end
      end else begin
        win_b = pick_b(a_req, b_req);
        rw = win_b ? b_rw : a_rw;
        ad = win_b ? b_addr : a_addr;
        wd = win_b ? b_wdata : a_wdata;
        grant_cycle();
        model_commit(win_b, rw, ad, wd);
        n_checks++;
        if (obs_ack2 !== (win_b ? 2'b01 : 2'b10) || obs_ar !== m_a_rdata || obs_br !== m_b_rdata) begin
          n_errors++;
          $display("FAIL rnd%0d: ack %b ard %h brd %h expected %b %h %h", it, obs_ack2, obs_ar, obs_br,
                   win_b ? 2'b01 : 2'b10, m_a_rdata, m_b_rdata);
        end
        if (win_b) b_req = 0;
        else a_req = 0;
        close_cycle();
        n_checks++;
        if (obs_ack3 !== 2'b00) begin
          n_errors++;
          $display("FAIL rnd_pulse%0d: ack got %b expected 00", it, obs_ack3);
        end
      end
    end
    a_req = 0; b_req = 0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    test_reset();
    test_write_read_a();
    test_cross_port();
    test_simultaneous();
    test_reset_mid();
    test_held_request();
    test_fill();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
